nic: RTL and testbench
======================

# nic

Network interface controller between a processing element and the router's PE port. The PE sees four 64-bit memory-mapped registers: input data, input status, output data and output status. The network side uses the router's send/ready handshake and the router's `polarity` signal. Each direction has a small FIFO. Outgoing packets are injected only in the cycle whose router polarity matches the packet's virtual-channel bit (bit 63).

## Interface
- `DATA_WIDTH`, 64: packet and register width.
- `DEPTH`, 2: entries per FIFO, in each direction. Must be a power of 2 and at least 1.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `addr`  in  2: register select. 00 = input data, 01 = input status, 10 = output data, 11 = output status.
- `nicEn`  in  1: PE access enable.
- `nicWrEn`  in  1: 1 = write, 0 = read; qualified by `nicEn`.
- `d_in`  in  64: PE write data.
- `d_out`  out  64: PE read data (combinational).
- `net_si`  in  1: router has a packet for the PE (router `peso`).
- `net_di`  in  64: packet from the router (router `pedo`).
- `net_ri`  out  1: NIC can accept a packet (to router `pero`).
- `net_so`  out  1: NIC is injecting a packet (to router `pesi`).
- `net_do`  out  64: injected packet (to router `pedi`).
- `net_ro`  in  1: router can accept a packet (router `peri`).
- `net_polarity`  in  1: router polarity; toggles every cycle.

## Operation
- **Input FIFO (IF).**
  - `net_ri` = !IF_full.
  - When `net_si` && `net_ri`, `net_di` is pushed at the clock edge.
- **Output FIFO (OF).**
  - Head of OF drives `net_do`; `net_do` is 0 when OF is empty.
  - `net_so` = !OF_empty && `net_ro` && (OF_head[63] == `net_polarity`).
  - When `net_so` is high, the head is popped at that clock edge.
- **PE reads** (`nicEn`=1, `nicWrEn`=0).
  - 00: `d_out` = IF head. Pops IF at the edge if IF is non-empty. If IF is empty, `d_out`=0 and there is no pop.
  - 01: `d_out` = {63'b0, !IF_empty}.
  - 10: `d_out` = 0.
  - 11: `d_out` = {63'b0, OF_full}.
- **PE writes** (`nicEn`=1, `nicWrEn`=1).
  - 10: pushes `d_in` into OF if !OF_full; otherwise the write is dropped and no state changes.
  - Writes to 00, 01 and 11 are ignored.
- `d_out` = 0 whenever `nicEn`=0 or `nicWrEn`=1.
- **Simultaneous events.**
  - IF push and PE pop in the same cycle: both occur; the count is unchanged.
  - OF push and network pop in the same cycle: both occur.
  - Full/empty decisions use pre-edge state only. A pop does not free space for a same-cycle push when the FIFO was full.
- **Storage.** Each FIFO has read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - DEPTH=1 uses a single valid bit.
  - Order is strictly FIFO, with no reordering by VC bit. A head whose VC bit mismatches waits at most one cycle for the polarity to flip.

## Timing
- **Reset** (`reset`=0, async): pointers, counts and storage clear to 0.
  - Outputs: `net_so`=0, `net_do`=0, `net_ri`=1, `d_out`=0.
  - Reset asserted mid-transfer discards all buffered packets; no partial state survives.
- **Network receive to PE visibility:** a packet captured at edge N is visible at status 01 and at `d_out` (addr 00) in cycle N+1.
- **PE write to injection:** a write at edge N is visible at `net_do` in cycle N+1.
  - `net_so` rises in cycle N+1 if the polarity matches and `net_ro`=1; otherwise in N+2, with `net_ro` permitting.
- **Full-FIFO recovery:** `net_ri` and OF_full change only after clock edges, one cycle after the push/pop that caused them.
- **Back-to-back throughput:** the network side can push or pop one packet per cycle, subject to polarity on output.

## Test plan
- **Reset:** drive `reset`=0 mid-stream with both FIFOs non-empty.
  - Required: `net_so`=0, `net_ri`=1, status 01 reads 0, status 11 reads 0, `d_out`=0.
- **Receive path:** `net_si`=1, `net_di`=64'hA5A5_0000_0000_0001 for one cycle.
  - Next cycle: status 01 reads 1 and addr 00 reads A5A5_0000_0000_0001.
  - The cycle after the read: status 01 reads 0.
- **Input back-pressure:** push DEPTH+1 packets 1, 2, 3 with no PE reads.
  - `net_ri`=0 after packet 2; packet 3 is held by the router.
  - Reading 1 then 2 returns them in order; `net_ri` returns to 1 after the first read.
- **Polarity gating:** write 64'h8000_0000_0000_00FF with `net_ro`=1.
  - `net_so` is asserted only in cycles with `net_polarity`=1, for exactly one cycle, with `net_do`=8000_0000_0000_00FF.
  - Repeat with bit 63=0; injection occurs when `net_polarity`=0.
- **Output full and drop:** `net_ro`=0, write 1, 2, 3.
  - Status 11 reads 1 after the second write; packet 3 is dropped.
  - Release `net_ro`: 1 then 2 are injected, status 11 returns to 0, and 3 never appears.
- **Simultaneous events:** with IF holding one packet, assert `net_si` and an addr-00 read in the same cycle.
  - The new packet is retained and status stays 1.
  - Do the same on the output side: OF push and injection in the same cycle keep the count constant.

Source files
------------

// File: rtl/nic.sv
// Network interface controller: PE-visible register file in front of two small
// FIFOs, with output injection gated by the router's virtual-channel polarity.

module nic_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    // push/pop arrive pre-qualified by the caller against full/empty
    if (DEPTH == 1) begin : g_one
        logic         vld;
        logic [W-1:0] mem;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vld <= 1'b0;
                mem <= '0;
            end else begin
                if (push) mem <= din;
                if (push)     vld <= 1'b1;
                else if (pop) vld <= 1'b0;
            end
        end

        assign head  = mem;
        assign empty = !vld;
        assign full  = vld;
    end else begin : g_ring
        localparam int AW = $clog2(DEPTH);
        localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

        logic [DEPTH-1:0][W-1:0] mem;
        logic [AW-1:0]           rd_ptr, wr_ptr;
        logic [AW:0]             cnt;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem    <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop) rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end

        assign head  = mem[rd_ptr];
        assign empty = (cnt == '0);
        assign full  = (cnt == FULL_CNT);
    end
endmodule

module nic #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  net_si,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_ri,
    output logic                  net_so,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_ro,
    input  logic                  net_polarity
);
    localparam logic [1:0] A_IN_DATA  = 2'b00;
    localparam logic [1:0] A_IN_STAT  = 2'b01;
    localparam logic [1:0] A_OUT_DATA = 2'b10;
    localparam logic [1:0] A_OUT_STAT = 2'b11;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [1:0] addr;
    } pe_req_t;

    pe_req_t req;
    assign req = '{rd: nicEn && !nicWrEn, wr: nicEn && nicWrEn, addr: addr};

    logic [DATA_WIDTH-1:0] if_head, of_head;
    logic                  if_empty, if_full, of_empty, of_full;
    logic                  if_push, if_pop, of_push;

    // full/empty are pre-edge, so a same-cycle pop never frees room for a push
    assign if_push = net_si && !if_full;
    assign if_pop  = req.rd && (req.addr == A_IN_DATA) && !if_empty;
    assign of_push = req.wr && (req.addr == A_OUT_DATA) && !of_full;

    nic_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_if (
        .clk(clk), .reset(reset), .push(if_push), .pop(if_pop),
        .din(net_di), .head(if_head), .empty(if_empty), .full(if_full)
    );

    nic_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_of (
        .clk(clk), .reset(reset), .push(of_push), .pop(net_so),
        .din(d_in), .head(of_head), .empty(of_empty), .full(of_full)
    );

    assign net_ri = !if_full;
    // head waits in order for its VC's polarity; no bypass of a blocked head
    assign net_so = !of_empty && net_ro && (of_head[DATA_WIDTH-1] == net_polarity);
    assign net_do = of_empty ? '0 : of_head;

    always_comb begin
        d_out = '0;
        if (req.rd) begin
            case (req.addr)
                A_IN_DATA:  d_out = if_empty ? '0 : if_head;
                A_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, !if_empty};
                A_OUT_DATA: d_out = '0;
                A_OUT_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, of_full};
                default:    d_out = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_nic.sv
// Scoreboard bench for nic: stimulus queues expected PE reads and injections,
// a negedge monitor checks them whenever the DUT presents a read or net_so.

module tb_nic;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  addr = 2'b00;
    logic        nicEn = 1'b0, nicWrEn = 1'b0;
    logic [63:0] d_in = '0, d_out;
    logic        net_si = 1'b0, net_ri, net_so, net_ro = 1'b0;
    logic [63:0] net_di = '0, net_do;
    logic        net_polarity = 1'b0;

    int tests = 0, fails = 0;
    logic [63:0] rd_q[$];
    logic [63:0] inj_q[$];

    nic #(.DATA_WIDTH(64), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .addr(addr), .nicEn(nicEn), .nicWrEn(nicWrEn),
        .d_in(d_in), .d_out(d_out), .net_si(net_si), .net_di(net_di),
        .net_ri(net_ri), .net_so(net_so), .net_do(net_do), .net_ro(net_ro),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;
    always @(posedge clk) net_polarity <= ~net_polarity;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every PE read and every injection consumes one expectation
    always @(negedge clk) begin
        if (reset) begin
            if (nicEn && !nicWrEn) begin
                if (rd_q.size() == 0) chk("rd_unexpected", d_out, 64'hx);
                else chk("pe_read", d_out, rd_q.pop_front());
            end
            if (net_so) begin
                if (inj_q.size() == 0) chk("inj_unexpected", net_do, 64'hx);
                else begin
                    logic [63:0] e;
                    e = inj_q.pop_front();
                    chk("inj_data", net_do, e);
                    chk("inj_polarity", {63'b0, net_polarity}, {63'b0, e[63]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [63:0] exp);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        rd_q.push_back(exp);
        tick();
        nicEn = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [63:0] d);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = a; d_in = d;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    task automatic rx(input logic [63:0] d);
        net_si = 1'b1; net_di = d;
        tick();
        net_si = 1'b0;
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (inj_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        chk(name, 64'(inj_q.size()), 64'd0);
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_so", {63'b0, net_so}, 64'd0);
        chk("rst_ri", {63'b0, net_ri}, 64'd1);
        chk("rst_do", net_do, 64'd0);
        chk("rst_dout", d_out, 64'd0);
        reset = 1'b1;
        tick();
        rd(2'b01, 64'd0);
        rd(2'b11, 64'd0);
        rd(2'b00, 64'd0);
        rd(2'b10, 64'd0);

        // receive path
        rx(64'hA5A5_0000_0000_0001);
        rd(2'b01, 64'd1);
        rd(2'b00, 64'hA5A5_0000_0000_0001);
        rd(2'b01, 64'd0);

        // input back-pressure
        rx(64'd1);
        chk("bp_ri_after1", {63'b0, net_ri}, 64'd1);
        rx(64'd2);
        chk("bp_ri_full", {63'b0, net_ri}, 64'd0);
        net_si = 1'b1; net_di = 64'd3;
        tick();
        chk("bp_ri_held", {63'b0, net_ri}, 64'd0);
        net_si = 1'b0;
        rd(2'b00, 64'd1);
        chk("bp_ri_recover", {63'b0, net_ri}, 64'd1);
        rd(2'b00, 64'd2);
        rd(2'b01, 64'd0);

        // polarity gating, both VCs
        net_ro = 1'b1;
        inj_q.push_back(64'h8000_0000_0000_00FF);
        wr(2'b10, 64'h8000_0000_0000_00FF);
        drain("pol_vc1_drain", 2);
        inj_q.push_back(64'h0000_0000_0000_00AA);
        wr(2'b10, 64'h0000_0000_0000_00AA);
        drain("pol_vc0_drain", 2);
        chk("pol_idle_so", {63'b0, net_so}, 64'd0);
        chk("pol_idle_do", net_do, 64'd0);

        // output full and drop
        net_ro = 1'b0;
        inj_q.push_back(64'd1);
        wr(2'b10, 64'd1);
        rd(2'b11, 64'd0);
        inj_q.push_back(64'd2);
        wr(2'b10, 64'd2);
        rd(2'b11, 64'd1);
        wr(2'b10, 64'd3);
        rd(2'b11, 64'd1);
        chk("of_hold_so", {63'b0, net_so}, 64'd0);
        net_ro = 1'b1;
        drain("of_drain", 8);
        repeat (4) tick();
        rd(2'b11, 64'd0);

        // simultaneous IF push and PE pop
        rx(64'h11);
        net_si = 1'b1; net_di = 64'h22;
        rd(2'b00, 64'h11);
        net_si = 1'b0;
        rd(2'b01, 64'd1);
        rd(2'b00, 64'h22);
        rd(2'b01, 64'd0);

        // simultaneous OF push and injection
        net_ro = 1'b0;
        inj_q.push_back(64'h33);
        wr(2'b10, 64'h33);
        while (net_polarity != 1'b0) tick();
        net_ro = 1'b1;
        inj_q.push_back(64'h8000_0000_0000_0044);
        wr(2'b10, 64'h8000_0000_0000_0044);
        net_ro = 1'b0;
        chk("sim_of_popped", 64'(inj_q.size()), 64'd1);
        rd(2'b11, 64'd0);
        inj_q.push_back(64'h55);
        wr(2'b10, 64'h55);
        rd(2'b11, 64'd1);
        net_ro = 1'b1;
        drain("sim_of_drain", 8);

        // reset mid-stream with both FIFOs occupied
        net_ro = 1'b0;
        rx(64'h66);
        wr(2'b10, 64'h8000_0000_0000_0077);
        reset = 1'b0;
        #2;
        chk("mid_rst_so", {63'b0, net_so}, 64'd0);
        chk("mid_rst_ri", {63'b0, net_ri}, 64'd1);
        chk("mid_rst_do", net_do, 64'd0);
        chk("mid_rst_dout", d_out, 64'd0);
        nicEn = 1'b1; addr = 2'b01;
        #1 chk("mid_rst_stat01", d_out, 64'd0);
        addr = 2'b11;
        #1 chk("mid_rst_stat11", d_out, 64'd0);
        nicEn = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        rd(2'b01, 64'd0);
        rd(2'b11, 64'd0);
        net_ro = 1'b1;
        repeat (4) tick();

        chk("rd_q_empty", 64'(rd_q.size()), 64'd0);
        chk("inj_q_empty", 64'(inj_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
